// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the controller decode.
// Contents: md_op encodings, the run-state type, and an operand-class helper.
// Nothing here holds state; it is imported by muldiv_unit.

package muldiv_unit_pkg;

    // md_op encodings. Values 6 and 7 are reserved and treated as no-ops.
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // The unit is idle when its down-counter is zero and running otherwise.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // MULT and DIV take two's complement operands; MULTU and DIVU take unsigned ones.
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers, plus MTHI/MTLO writes.
// Ports: clk/reset (async, active-high); start+md_op+A/B from the E stage;
//        busy to the stall unit; HI/LO read directly by MFHI/MFLO.

module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_q, pend_d;      // {HI, LO} waiting for the final busy cycle
    logic             pend_vld_q, pend_vld_d; // cleared for divide-by-zero so HI/LO are kept
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    md_state_e state;

    logic               op_signed;
    logic               b_zero;
    logic signed [63:0] mul_a, mul_b, prod;
    logic signed [32:0] div_a, div_b;

    assign state     = (cnt_q == '0) ? ST_IDLE : ST_RUN;
    assign op_signed = md_is_signed(md_op);
    assign b_zero    = (B == 32'd0);

    // A 64-bit product of 64-bit-extended operands is exact for both signednesses.
    assign mul_a = op_signed ? {{32{A[31]}}, A} : {32'd0, A};
    assign mul_b = op_signed ? {{32{B[31]}}, B} : {32'd0, B};
    assign prod  = mul_a * mul_b;

    // 33-bit division: 0x80000000 / -1 yields +2^31 without overflow, and its low
    // 32 bits give the wrapped 0x80000000. A zero divisor is swapped for 1 so the
    // divider never sees it; that result is discarded anyway.
    assign div_a = op_signed ? {A[31], A} : {1'b0, A};
    assign div_b = b_zero ? 33'sd1 : (op_signed ? {B[31], B} : {1'b0, B});

    always_comb begin
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            pend_d     = prod;
                            pend_vld_d = 1'b1;
                            cnt_d      = CNT_W'(MULT_CYCLES);
                        end
                        MD_DIV, MD_DIVU: begin
                            // Remainder in HI, quotient in LO; SV / and % truncate
                            // toward zero with the remainder taking the dividend's sign.
                            pend_d     = {32'(div_a % div_b), 32'(div_a / div_b)};
                            pend_vld_d = !b_zero;
                            cnt_d      = CNT_W'(DIV_CYCLES);
                        end
                        MD_MTHI: hi_d = A;
                        MD_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // start is ignored here; the stall unit keeps md/mt ops out of E.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy = (state == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit: directed cases, then randomized operations
// checked against an arithmetic reference model held in the bench.

module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];

    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;

    muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural effect of one accepted operation.
    // Returns the busy length (0 for ops that complete without busy).
    task automatic apply_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int cyc);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, up, uq, ur;
        cyc = 0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (op)
            3'd0: begin
                sq = sa * sb;
                mdl_hi = sq[63:32]; mdl_lo = sq[31:0]; cyc = 5;
            end
            3'd1: begin
                up = ua * ub;
                mdl_hi = up[63:32]; mdl_lo = up[31:0]; cyc = 5;
            end
            3'd2: begin
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    mdl_hi = sr[31:0]; mdl_lo = sq[31:0];
                end
                cyc = 10;
            end
            3'd3: begin
                if (b != 0) begin
                    uq = ua / ub; ur = ua % ub;
                    mdl_hi = ur[31:0]; mdl_lo = uq[31:0];
                end
                cyc = 10;
            end
            3'd4: mdl_hi = a;
            3'd5: mdl_lo = a;
            default: ;
        endcase
    endtask

    // Monitor: measures each busy run and scores HI/LO when busy drops.
    int run_len = 0;
    bit in_run  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            in_run  = 0;
            run_len = 0;
        end else if (busy) begin
            in_run = 1;
            run_len++;
        end else if (in_run) begin
            in_run = 0;
            if (sb_q.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("busy_len", 32'(run_len), 32'(e.cyc));
                check("hi_commit", HI, e.hi);
                check("lo_commit", LO, e.lo);
            end
            run_len = 0;
        end
    end

    // Call just after a rising edge. Leaves the caller just after a rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit do_wait);
        int cyc;
        exp_t e;
        start = 1'b1; md_op = op; A = a; B = b;
        apply_model(op, a, b, cyc);
        if (cyc != 0) begin
            e.cyc = cyc; e.hi = mdl_hi; e.lo = mdl_lo;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom; md_op = 3'($urandom);
        check("busy_after_start", {31'd0, busy}, {31'd0, (cyc != 0)});
        if (cyc == 0) begin
            check("mt_hi", HI, mdl_hi);
            check("mt_lo", LO, mdl_lo);
        end else if (do_wait) begin
            wait_idle();
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            A = $urandom; B = $urandom;
            if (!busy) begin done = 1; break; end
        end
        if (!done) check("busy_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int k, bz;
        logic [2:0]  op;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; md_op = 3'd0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases with fixed expected values.
        issue(3'd0, 32'hFFFFFFFD, 32'd5, 1);
        check("mult_hi", HI, 32'hFFFFFFFF); check("mult_lo", LO, 32'hFFFFFFF1);
        issue(3'd1, 32'hFFFFFFFF, 32'd2, 1);
        check("multu_hi", HI, 32'h00000001); check("multu_lo", LO, 32'hFFFFFFFE);
        issue(3'd3, 32'd7, 32'd2, 1);
        check("divu_lo", LO, 32'd3); check("divu_hi", HI, 32'd1);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 1);
        check("div_lo", LO, 32'hFFFFFFFD); check("div_hi", HI, 32'hFFFFFFFF);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1);
        check("divovf_lo", LO, 32'h80000000); check("divovf_hi", HI, 32'd0);

        // Back-to-back MTHI then MTLO.
        issue(3'd4, 32'h12345678, 32'd0, 0);
        issue(3'd5, 32'h00000009, 32'd0, 0);
        check("mthi_val", HI, 32'h12345678); check("mtlo_val", LO, 32'd9);

        // MTLO arriving while a DIVU is busy is ignored.
        issue(3'd3, 32'd100, 32'd7, 0);
        repeat (2) @(posedge clk);
        #1; start = 1'b1; md_op = 3'd5; A = 32'hAA;
        @(posedge clk); #1; start = 1'b0;
        wait_idle();
        check("ignored_mt_lo", LO, 32'd14);

        // Divide by zero leaves preloaded HI/LO.
        issue(3'd4, 32'h55, 32'd0, 0);
        issue(3'd5, 32'h55, 32'd0, 0);
        issue(3'd2, 32'd1234, 32'd0, 1);
        check("div0_hi", HI, 32'h55); check("div0_lo", LO, 32'h55);

        // Reserved op changes nothing.
        issue(3'd6, 32'hDEAD, 32'hBEEF, 0);
        issue(3'd7, 32'hDEAD, 32'hBEEF, 0);

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom;
            bz = $urandom_range(0, 9);
            if (bz == 0) rb = 32'd0;
            if (bz == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (bz == 2) rb = 32'($urandom_range(1, 16));
            issue(op, ra, rb, 1);
        end

        // Reset in the middle of a DIV abandons it.
        issue(3'd2, 32'd1000, 32'd3, 0);
        repeat (3) @(posedge clk);
        #2; reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        void'(sb_q.pop_back());
        mdl_hi = 32'd0; mdl_lo = 32'd0;
        @(posedge clk); #1; reset = 1'b0;
        k = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy) k++;
        end
        check("postrst_busy_cycles", 32'(k), 32'd0);
        check("postrst_hi", HI, 32'd0);
        check("postrst_lo", LO, 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
